// File: rtl/spi_sensor_responder.sv
// SPI mode-3 slave modelling a gyro/accel sensor register map; SCLK/MOSI/SS are
// oversampled on div_clk and serve single or auto-incrementing reads and writes.
module spi_sensor_responder #(
  parameter logic [7:0]  WHO_AM_I_VAL = 8'hD4,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        div_clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS,
  output logic        MISO,
  input  logic        host_wr_en,
  input  logic [2:0]  host_wr_addr,
  input  logic [7:0]  host_wr_data,
  output logic [63:0] ctrl_out,
  output logic        spi_wr_strobe,
  output logic [5:0]  spi_wr_addr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic       sclk_d;
  logic       sclk_s, mosi_s, ss_s;
  logic       rise, fall, byte_done;
  logic [2:0] bit_cnt;
  logic [6:0] rx;
  logic [7:0] rx_byte;
  logic [7:0] tx;
  logic [5:0] addr, next_addr, rd_addr;
  logic       ms;
  logic [7:0] rd_data;
  logic       miso_q;
  logic [7:0] ctrl_q [0:7];
  logic [7:0] data_q [0:5];

  // Synchronizers reset to idle bus levels so no false select or SCLK edge follows reset.
  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '1;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx, mosi_s};
  assign next_addr = ms ? addr + 6'd1 : addr;
  // In CMD the load uses the address still arriving on the wire, not the latched one.
  assign rd_addr   = (state == CMD) ? rx_byte[5:0] : next_addr;

  always_comb begin
    rd_data = '0;
    if (rd_addr == 6'h0F)
      rd_data = WHO_AM_I_VAL;
    else if (rd_addr[5:3] == 3'b100)
      rd_data = ctrl_q[rd_addr[2:0]];
    else if (rd_addr[5:3] == 3'b101 && rd_addr[2:0] < 3'd6)
      rd_data = data_q[rd_addr[2:0]];
  end

  always_comb begin
    state_next = state;
    if (ss_s) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = CMD;
        CMD:     if (byte_done) state_next = rx_byte[7] ? RD : WR;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge div_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rx            <= '0;
      tx            <= '0;
      addr          <= '0;
      ms            <= 1'b0;
      miso_q        <= 1'b0;
      spi_wr_strobe <= 1'b0;
      spi_wr_addr   <= '0;
      for (int unsigned i = 0; i < 8; i++) ctrl_q[i] <= '0;
      for (int unsigned i = 0; i < 6; i++) data_q[i] <= '0;
    end else begin
      state         <= state_next;
      spi_wr_strobe <= 1'b0;
      if (host_wr_en && host_wr_addr < 3'd6)
        data_q[host_wr_addr] <= host_wr_data;

      if (ss_s || state == IDLE) begin
        bit_cnt <= '0;
        miso_q  <= 1'b0;
      end else begin
        if (rise) begin
          rx      <= {rx[5:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          CMD: begin
            miso_q <= 1'b0;
            if (byte_done) begin
              ms   <= rx_byte[6];
              addr <= rx_byte[5:0];
              if (rx_byte[7]) tx <= rd_data;
            end
          end
          RD: begin
            if (fall) begin
              miso_q <= tx[7];
              tx     <= {tx[6:0], 1'b0};
            end
            if (byte_done) begin
              addr <= next_addr;
              tx   <= rd_data;
            end
          end
          WR: begin
            miso_q <= 1'b0;
            if (byte_done) begin
              if (addr[5:3] == 3'b100) begin
                ctrl_q[addr[2:0]] <= rx_byte;
                spi_wr_strobe     <= 1'b1;
                spi_wr_addr       <= addr;
              end
              addr <= next_addr;
            end
          end
          default: miso_q <= 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int unsigned k = 0; k < 8; k++) ctrl_out[8*k +: 8] = ctrl_q[k];
  end

  assign MISO = miso_q;
  assign busy = ~ss_s;

endmodule

// File: tb/tb_spi_sensor_responder.sv
// Bench for spi_sensor_responder: bit-banged SPI master against a register-map
// model holding ctrl/data arrays and address-walk arithmetic.
module tb_spi_sensor_responder;

  logic        div_clk = 1'b0;
  logic        reset;
  logic        SCLK, MOSI, SS, MISO;
  logic        host_wr_en;
  logic [2:0]  host_wr_addr;
  logic [7:0]  host_wr_data;
  logic [63:0] ctrl_out;
  logic        spi_wr_strobe;
  logic [5:0]  spi_wr_addr;
  logic        busy;

  localparam int HALF = 6;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  logic [5:0] strobe_addr_last = '0;

  logic [7:0] ctrl_m [8];
  logic [7:0] data_m [6];
  logic [7:0] tx_buf [16];
  logic [7:0] rx_buf [16];

  spi_sensor_responder #(.WHO_AM_I_VAL(8'hD4), .SYNC_STAGES(2)) dut (
    .div_clk(div_clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .ctrl_out(ctrl_out), .spi_wr_strobe(spi_wr_strobe), .spi_wr_addr(spi_wr_addr), .busy(busy)
  );

  always #5 div_clk = ~div_clk;

  always @(negedge div_clk) begin
    if (spi_wr_strobe === 1'b1) begin
      strobe_cnt++;
      strobe_addr_last = spi_wr_addr;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge div_clk);
  endtask

  function automatic logic [7:0] model_read(input logic [5:0] a);
    int ai = int'(a);
    if (ai == 15) return 8'hD4;
    if (ai >= 32 && ai <= 39) return ctrl_m[ai - 32];
    if (ai >= 40 && ai <= 45) return data_m[ai - 40];
    return 8'h00;
  endfunction

  function automatic logic [63:0] model_ctrl();
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = ctrl_m[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) ctrl_m[k] = 8'h00;
    for (int k = 0; k < 6; k++) data_m[k] = 8'h00;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      SCLK = 1'b0; MOSI = b[i]; tick(HALF);
      r[i] = MISO; SCLK = 1'b1; tick(HALF);
    end
  endtask

  task automatic host_write(input int idx, input logic [7:0] val);
    host_wr_en = 1'b1; host_wr_addr = 3'(idx); host_wr_data = val;
    tick(1);
    host_wr_en = 1'b0;
    if (idx < 6) data_m[idx] = val;
  endtask

  // Runs a full frame, then checks read bytes, strobes and ctrl_out against the model.
  task automatic run_frame(input logic [7:0] cmd, input int nbytes, input string tag);
    logic [7:0] r;
    logic [5:0] a;
    int s0, exp_strobes;
    logic [5:0] exp_last;
    s0 = strobe_cnt; exp_strobes = 0; exp_last = '0;
    SS = 1'b0; tick(HALF);
    spi_bits(cmd, 8, r);
    for (int i = 0; i < nbytes; i++) begin
      spi_bits(tx_buf[i], 8, r);
      rx_buf[i] = r;
    end
    check({tag, "_busy"}, 64'(busy), 64'd1);
    tick(HALF); SS = 1'b1; tick(HALF);
    check({tag, "_miso_idle"}, 64'(MISO), 64'd0);
    check({tag, "_busy_idle"}, 64'(busy), 64'd0);
    a = cmd[5:0];
    for (int i = 0; i < nbytes; i++) begin
      if (cmd[7]) begin
        check($sformatf("%s_rd%0d", tag, i), 64'(rx_buf[i]), 64'(model_read(a)));
      end else if (int'(a) >= 32 && int'(a) <= 39) begin
        ctrl_m[int'(a) - 32] = tx_buf[i];
        exp_strobes++;
        exp_last = a;
      end
      if (cmd[6]) a = a + 6'd1;
    end
    check({tag, "_strobes"}, 64'(strobe_cnt - s0), 64'(exp_strobes));
    if (exp_strobes > 0) check({tag, "_wr_addr"}, 64'(strobe_addr_last), 64'(exp_last));
    check({tag, "_ctrl"}, ctrl_out, model_ctrl());
  endtask

  initial begin
    logic [7:0] r, cmd;
    int s0, n, sel;
    logic [5:0] a;

    reset = 1'b1; SS = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    model_clear();
    tick(3);
    check("rst_miso", 64'(MISO), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ctrl", ctrl_out, 64'd0);
    check("rst_strobe", 64'(spi_wr_strobe), 64'd0);
    check("rst_wr_addr", 64'(spi_wr_addr), 64'd0);
    reset = 1'b0;
    tick(4);

    tx_buf[0] = 8'h00;
    run_frame(8'h8F, 1, "whoami");

    tx_buf[0] = 8'h0F;
    run_frame(8'h20, 1, "wr20");
    check("wr20_byte0", 64'(ctrl_out[7:0]), 64'h0F);
    tx_buf[0] = 8'h00;
    run_frame(8'hA0, 1, "rd20");

    for (int i = 0; i < 6; i++) host_write(i, 8'(8'h11 + i));
    for (int i = 0; i < 6; i++) tx_buf[i] = 8'h00;
    run_frame(8'hE8, 6, "burst28");
    run_frame(8'hA8, 6, "hold28");

    tx_buf[0] = 8'hAB; tx_buf[1] = 8'hCD;
    run_frame(8'h67, 2, "wr27");
    check("wr27_byte7", 64'(ctrl_out[63:56]), 64'hAB);
    check("wr27_last", 64'(strobe_addr_last), 64'h27);

    // Partial data byte: SS rises after five bits.
    s0 = strobe_cnt;
    SS = 1'b0; tick(HALF);
    spi_bits(8'h21, 8, r);
    spi_bits(8'h5A, 5, r);
    tick(HALF); SS = 1'b1; tick(HALF);
    check("partial_busy", 64'(busy), 64'd0);
    check("partial_strobes", 64'(strobe_cnt - s0), 64'd0);
    check("partial_byte1", 64'(ctrl_out[15:8]), 64'h00);
    tx_buf[0] = 8'h00;
    run_frame(8'hA1, 1, "rd21");

    tx_buf[0] = 8'h00; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    run_frame(8'hCD, 3, "walk0d");
    run_frame(8'hE6, 3, "walk26");
    host_write(6, 8'h99);
    run_frame(8'hEC, 3, "walk2c");

    // Randomized frames mixed with host loads.
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) host_write(int'($urandom_range(0, 7)), 8'($urandom));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: a = 6'($urandom);
        1: a = 6'(6'h20 + $urandom_range(0, 7));
        2: a = 6'(6'h28 + $urandom_range(0, 5));
        default: a = ($urandom_range(0, 1) == 1) ? 6'h0F : 6'h3F;
      endcase
      cmd = {1'($urandom), 1'($urandom), a};
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) tx_buf[i] = 8'($urandom);
      run_frame(cmd, n, $sformatf("rnd%0d", k));
    end

    // Reset in the middle of a write of 0x55 to 0x22.
    tx_buf[0] = 8'hE1;
    run_frame(8'h20, 1, "prefill");
    SS = 1'b0; tick(HALF);
    spi_bits(8'h22, 8, r);
    spi_bits(8'h55, 4, r);
    reset = 1'b1;
    tick(2);
    check("midrst_miso", 64'(MISO), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ctrl", ctrl_out, 64'd0);
    check("midrst_strobe", 64'(spi_wr_strobe), 64'd0);
    check("midrst_wr_addr", 64'(spi_wr_addr), 64'd0);
    SS = 1'b1; SCLK = 1'b1; tick(2);
    reset = 1'b0;
    model_clear();
    tick(HALF);
    check("postrst_byte2", 64'(ctrl_out[23:16]), 64'h00);
    tx_buf[0] = 8'h00;
    run_frame(8'hA2, 1, "rd22");
    run_frame(8'hA8, 1, "rd28_cleared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sensor_responder.md
Name: spi_sensor_responder

Overview:
- Synthesizable SPI slave (mode 3) that models the register-level behaviour of a gyro/accel sensor.
- It is the far end of the spi_interface master. It is used as an on-chip loopback target and as a bench model behind SS_G/SS_A.
- SCLK, MOSI and SS are oversampled on div_clk. The block decodes an 8-bit command byte and serves single or auto-incrementing register reads and writes from a 64-entry address map.

Parameters:
- WHO_AM_I_VAL, 8'hD4, constant returned at address 0x0F.
- SYNC_STAGES, 2, synchronizer depth for SCLK/MOSI/SS (allowed 2..3).

Ports:
- div_clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- SCLK  input  1  SPI clock from master; idles high.
- MOSI  input  1  master-to-slave data.
- SS  input  1  active-low slave select.
- MISO  output  1  slave-to-master data; 0 when SS high.
- host_wr_en  input  1  load one sensor data register.
- host_wr_addr  input  3  data register index 0..5, mapping to 0x28..0x2D.
- host_wr_data  input  8  value to load.
- ctrl_out  output  64  control registers 0x20..0x27; byte k is bits [8k+7:8k].
- spi_wr_strobe  output  1  one-cycle pulse on each accepted SPI register write.
- spi_wr_addr  output  6  address of the write accepted with that strobe.
- busy  output  1  high while SS (synchronized) is low.

Behaviour:
- Reset: all outputs 0, all registers 0, FSM to IDLE. Reset mid-transfer aborts immediately; no register write completes.
- Inputs pass through SYNC_STAGES flops.
- Edges are detected from the last two synchronized SCLK samples.
  - MOSI is sampled on each SCLK rising edge.
  - MISO shifts on each SCLK falling edge.
- Timing requirement: SCLK high and low phases must each be at least SYNC_STAGES+1 div_clk cycles.
- Frame: SS falling, then command byte, then N data bytes, then SS rising.
  - Command byte bit7 = RW (1 = read).
  - Bit6 = MS (1 = auto-increment).
  - Bits5:0 = start address.
- FSM states: IDLE, CMD, RD, WR.
  - IDLE to CMD on SS low; bit counter cleared.
  - CMD: after the 8th rising edge, latch RW, MS and address, then go to RD or WR.
  - RD: the shift register loads the addressed byte in the cycle the 8th command bit is captured. The MSB drives MISO from the next SCLK falling edge. Each further byte reloads after every 8th rising edge.
  - WR: after every 8th rising edge, the completed byte is written to the current address.
  - Any state returns to IDLE when SS goes high. A partial byte is discarded; MISO goes to 0 the cycle after SS high is seen.
- Address advance: after each data byte, address increments by 1 if MS=1 and wraps 0x3F to 0x00. If MS=0 the address is held.
- Read map:
  - 0x0F returns WHO_AM_I_VAL.
  - 0x20..0x27 return ctrl registers.
  - 0x28..0x2D return host data registers.
  - All other addresses return 0x00.
- Write map:
  - Only 0x20..0x27 are writable. Each accepted write pulses spi_wr_strobe with spi_wr_addr one cycle after the byte completes.
  - Writes to any other address are ignored and produce no strobe.
- Read data is snapshotted at shift-register load. A host_wr_en to the same register during byte transmission affects the next read only.
- host_wr_en is accepted every cycle regardless of SPI activity. It never conflicts with SPI writes because the address ranges are disjoint.
- During CMD and WR, MISO = 0.
- SCLK edges while SS is high are ignored.

Test Plan:
- Reset, then command 0x8F plus one dummy byte. MISO returns 0xD4 MSB-first; busy is high during the frame; MISO is 0 after SS rises.
- Command 0x20 followed by data 0x0F. ctrl_out[7:0]=0x0F; spi_wr_strobe pulses once with spi_wr_addr=0x20. A subsequent 0xA0 read returns 0x0F.
- host_wr loads 0x11..0x16 into indices 0..5, then command 0xE8 with 6 dummy bytes. MISO yields 0x11,0x12,0x13,0x14,0x15,0x16. With command 0xA8 instead, all bytes read 0x11.
- Command 0x67 with data 0xAB, 0xCD. ctrl_out[63:56]=0xAB; one strobe at 0x27; 0x28 is unchanged and produces no second strobe.
- Command 0x21 with SS raised after 5 data bits. ctrl_out[15:8] stays 0, no strobe, and the FSM returns to IDLE. The next frame (0xA1) reads 0x00 correctly.
- Assert reset mid-way through a write of 0x55 to 0x22. All outputs are 0 and ctrl_out[23:16]=0 after reset.
